// File: rtl/food_placer.sv
// food_placer: picks the next food cell after the snake eats.
// Draws LFSR candidates, rejects walls, scans the snake body one piece per cycle, falls back to a sweep.
module food_placer #(
  parameter int unsigned GRID_WIDTH       = 32,
  parameter int unsigned GRID_HEIGHT      = 24,
  parameter int unsigned NUM_SNAKE_PIECES = 16,
  parameter int unsigned MAX_TRIES        = 8,
  localparam int unsigned XB = $clog2(GRID_WIDTH),
  localparam int unsigned YB = $clog2(GRID_HEIGHT),
  localparam int unsigned PB = $clog2(NUM_SNAKE_PIECES)
) (
  input  logic          Clock,
  input  logic          ResetN,
  input  logic          Request,
  input  logic [PB-1:0] SnakeTail,
  output logic [PB-1:0] PieceIndex,
  input  logic [YB-1:0] PieceY,
  input  logic [XB-1:0] PieceX,
  output logic [YB-1:0] FoodY,
  output logic [XB-1:0] FoodX,
  output logic          Busy,
  output logic          Done
);

  localparam int unsigned   TRIES_BITS = $clog2(MAX_TRIES + 1);
  localparam logic [XB-1:0] X_MAX      = XB'(GRID_WIDTH - 2);
  localparam logic [YB-1:0] Y_MAX      = YB'(GRID_HEIGHT - 2);
  localparam logic [TRIES_BITS-1:0] LAST_TRY = TRIES_BITS'(MAX_TRIES - 1);
  localparam logic [15:0]   LFSR_MASK  = 16'hB400;
  localparam logic [15:0]   LFSR_SEED  = 16'hACE1;

  typedef enum logic [1:0] {IDLE, DRAW, SCAN, SWEEP} state_t;

  state_t                  state;
  logic [15:0]             lfsr;
  logic [15:0]             lfsrNext;
  logic [XB-1:0]           rawX;
  logic [XB-1:0]           candX;
  logic [YB-1:0]           rawY;
  logic [YB-1:0]           candY;
  logic [PB-1:0]           tailQ;
  logic [TRIES_BITS-1:0]   tries;
  logic                    sweepMode;
  logic                    rawInRange;
  logic                    pieceHit;

  // Galois LFSR step, raw candidate extraction, wall and body comparisons
  always_comb begin
    lfsrNext   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
    rawX       = lfsr[XB-1:0];
    rawY       = lfsr[15:16-YB];
    rawInRange = (rawX != '0) && (rawX <= X_MAX) && (rawY != '0) && (rawY <= Y_MAX);
    pieceHit   = (PieceY == candY) && (PieceX == candX);
  end

  // Sequencer; the LFSR free-runs in every state so draws decorrelate from game timing
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state      <= IDLE;
      lfsr       <= LFSR_SEED;
      FoodY      <= YB'(5);
      FoodX      <= XB'(10);
      Busy       <= 1'b0;
      Done       <= 1'b0;
      PieceIndex <= '0;
      tries      <= '0;
      tailQ      <= '0;
      candX      <= '0;
      candY      <= '0;
      sweepMode  <= 1'b0;
    end else begin
      lfsr <= lfsrNext;
      Done <= 1'b0;
      case (state)
        IDLE: begin
          PieceIndex <= '0;
          if (Request) begin
            tailQ     <= SnakeTail;
            tries     <= '0;
            sweepMode <= 1'b0;
            Busy      <= 1'b1;
            state     <= DRAW;
          end
        end
        DRAW: begin
          if (rawInRange) begin
            candY      <= rawY;
            candX      <= rawX;
            PieceIndex <= '0;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (pieceHit) begin
            PieceIndex <= '0;
            if (sweepMode || tries == LAST_TRY) begin
              sweepMode <= 1'b1;
              state     <= SWEEP;
            end else begin
              tries <= tries + TRIES_BITS'(1);
              state <= DRAW;
            end
          end else if (PieceIndex != tailQ) begin
            PieceIndex <= PieceIndex + PB'(1);
          end else begin
            FoodY      <= candY;
            FoodX      <= candX;
            Done       <= 1'b1;
            Busy       <= 1'b0;
            PieceIndex <= '0;
            state      <= IDLE;
          end
        end
        SWEEP: begin
          // raster step through the playfield interior, wrapping to (1,1)
          if (candX == X_MAX) begin
            candX <= XB'(1);
            candY <= (candY == Y_MAX) ? YB'(1) : candY + YB'(1);
          end else begin
            candX <= candX + XB'(1);
          end
          PieceIndex <= '0;
          state      <= SCAN;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_food_placer.sv
// Scoreboard bench for food_placer: stimulus pushes predicted commits, a monitor pops them on Done.
// dut0 uses the default try budget, dut1 is built with MAX_TRIES=1 to reach sweep mode quickly.
module tb_food_placer;

  typedef logic [4:0] coordArr [16];
  typedef struct {
    logic [4:0] fy;
    logic [4:0] fx;
    int         doneEdge;
    int         tail;
  } expItem;

  logic       Clock = 1'b0;
  logic       ResetN = 1'b1;
  logic       clkEn = 1'b0;
  logic       Request0 = 1'b0;
  logic       Request1 = 1'b0;
  logic [3:0] SnakeTail0 = '0;
  logic [3:0] SnakeTail1 = '0;
  logic [3:0] PieceIndex0, PieceIndex1;
  logic [4:0] PieceY0, PieceX0, PieceY1, PieceX1;
  logic [4:0] FoodY0, FoodX0, FoodY1, FoodX1;
  logic       Busy0, Done0, Busy1, Done1;

  coordArr py0, px0, py1, px1;
  expItem  q0[$];
  expItem  q1[$];

  int          nChecks = 0;
  int          nFails = 0;
  int          edgeCnt = 0;
  int          doneCnt0 = 0;
  int          doneCnt1 = 0;
  int          lastDone0 = -1;
  int          lastDone1 = -1;
  logic [15:0] mLfsr = 16'hACE1;

  assign PieceY0 = py0[PieceIndex0];
  assign PieceX0 = px0[PieceIndex0];
  assign PieceY1 = py1[PieceIndex1];
  assign PieceX1 = px1[PieceIndex1];

  food_placer dut0 (
    .Clock(Clock), .ResetN(ResetN), .Request(Request0), .SnakeTail(SnakeTail0),
    .PieceIndex(PieceIndex0), .PieceY(PieceY0), .PieceX(PieceX0),
    .FoodY(FoodY0), .FoodX(FoodX0), .Busy(Busy0), .Done(Done0)
  );

  food_placer #(.MAX_TRIES(1)) dut1 (
    .Clock(Clock), .ResetN(ResetN), .Request(Request1), .SnakeTail(SnakeTail1),
    .PieceIndex(PieceIndex1), .PieceY(PieceY1), .PieceX(PieceX1),
    .FoodY(FoodY1), .FoodX(FoodX1), .Busy(Busy1), .Done(Done1)
  );

  always begin
    #5;
    if (clkEn) Clock = ~Clock;
  end

  always @(posedge Clock) edgeCnt <= edgeCnt + 1;

  function automatic logic [15:0] lfsrStep(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  always @(posedge Clock or negedge ResetN) begin
    if (!ResetN) mLfsr <= 16'hACE1;
    else         mLfsr <= lfsrStep(mLfsr);
  end

  function automatic bit inRange(input logic [15:0] v);
    logic [4:0] x, y;
    x = v[4:0];
    y = v[15:11];
    return (x >= 5'd1) && (x <= 5'd30) && (y >= 5'd1) && (y <= 5'd22);
  endfunction

  // first in-range candidate the DUT will draw if Request is sampled on the next edge
  task automatic firstCand(input logic [15:0] v, output logic [4:0] cy, output logic [4:0] cx);
    logic [15:0] l;
    l = lfsrStep(v);
    for (int n = 0; n < 1000 && !inRange(l); n++) l = lfsrStep(l);
    cy = l[15:11];
    cx = l[4:0];
  endtask

  // behavioural reference: edges from the sampling edge to the commit edge, inclusive
  function automatic int predict(input logic [15:0] v, input int tail, input int maxTries,
                                 input coordArr py, input coordArr px,
                                 output logic [4:0] fy, output logic [4:0] fx);
    logic [15:0] l;
    logic [4:0]  cy, cx;
    int          lat, tries;
    bit          sweep, needDraw, hit;
    l = lfsrStep(v); lat = 1; tries = 0; sweep = 0; needDraw = 1;
    cy = '0; cx = '0; fy = '0; fx = '0;
    for (int guard = 0; guard < 20000; guard++) begin
      if (needDraw) begin
        if (inRange(l)) begin
          cy = l[15:11]; cx = l[4:0]; needDraw = 0;
        end
        l = lfsrStep(l); lat++;
      end else begin
        hit = 0;
        for (int i = 0; i <= tail && !hit; i++) begin
          l = lfsrStep(l); lat++;
          hit = (py[i] == cy) && (px[i] == cx);
        end
        if (!hit) begin
          fy = cy; fx = cx;
          return lat;
        end
        if (!sweep && tries + 1 < maxTries) begin
          tries++; needDraw = 1;
        end else begin
          sweep = 1;
          if (cx == 5'd30) begin
            cx = 5'd1;
            cy = (cy == 5'd22) ? 5'd1 : cy + 5'd1;
          end else begin
            cx = cx + 5'd1;
          end
          l = lfsrStep(l); lat++;
        end
      end
    end
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int req);
    nChecks++;
    if (act != req) begin
      nFails++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, edgeCnt);
    end
  endtask

  task automatic checkDone(input int which, input logic busy, input logic [4:0] fy, input logic [4:0] fx);
    expItem e;
    bit     free;
    int     last;
    if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
      nChecks++; nFails++;
      $display("FAIL dut%0d_unexpected_done: got Done=1, expected no Done (edge %0d)", which, edgeCnt);
      return;
    end
    if (which == 0) begin
      e = q0.pop_front(); doneCnt0++; last = lastDone0; lastDone0 = edgeCnt;
    end else begin
      e = q1.pop_front(); doneCnt1++; last = lastDone1; lastDone1 = edgeCnt;
    end
    check($sformatf("dut%0d_food_y", which), int'(fy), int'(e.fy));
    check($sformatf("dut%0d_food_x", which), int'(fx), int'(e.fx));
    check($sformatf("dut%0d_done_edge", which), edgeCnt, e.doneEdge);
    check($sformatf("dut%0d_busy_with_done", which), int'(busy), 0);
    check($sformatf("dut%0d_food_in_range", which),
          int'(fx >= 5'd1 && fx <= 5'd30 && fy >= 5'd1 && fy <= 5'd22), 1);
    free = 1;
    for (int i = 0; i <= e.tail; i++) begin
      if (which == 0 && py0[i] == fy && px0[i] == fx) free = 0;
      if (which == 1 && py1[i] == fy && px1[i] == fx) free = 0;
    end
    check($sformatf("dut%0d_food_free", which), int'(free), 1);
    if (last >= 0) check($sformatf("dut%0d_done_gap", which), int'(edgeCnt - last >= e.tail + 3), 1);
  endtask

  always @(negedge Clock) begin
    if (Done0) checkDone(0, Busy0, FoodY0, FoodX0);
    if (Done1) checkDone(1, Busy1, FoodY1, FoodX1);
  end

  task automatic waitEdge(input int target);
    while (edgeCnt < target) @(negedge Clock);
  endtask

  // call on a negedge: the following posedge is the sampling edge
  task automatic pushExp(input int which, input int tail, input int maxTries, output int de);
    expItem     e;
    logic [4:0] fy, fx;
    int         lat;
    if (which == 0) lat = predict(mLfsr, tail, maxTries, py0, px0, fy, fx);
    else            lat = predict(mLfsr, tail, maxTries, py1, px1, fy, fx);
    e.fy = fy; e.fx = fx; e.tail = tail; e.doneEdge = edgeCnt + lat;
    de = e.doneEdge;
    if (which == 0) begin SnakeTail0 = 4'(tail); q0.push_back(e); end
    else            begin SnakeTail1 = 4'(tail); q1.push_back(e); end
  endtask

  task automatic pulse(input int which, input int tail, input int maxTries);
    int de;
    pushExp(which, tail, maxTries, de);
    if (which == 0) Request0 = 1'b1; else Request1 = 1'b1;
    @(negedge Clock);
    Request0 = 1'b0; Request1 = 1'b0;
    waitEdge(de + 2);
    check($sformatf("dut%0d_queue_drained", which), (which == 0) ? q0.size() : q1.size(), 0);
  endtask

  // wait for a cycle whose first candidate sits in column 30, block it, expect the sweep wrap
  task automatic sweepTest();
    logic [15:0] v;
    logic [4:0]  cy, cx;
    int          found, de;
    expItem      e;
    @(negedge Clock);
    v = mLfsr; found = -1;
    for (int d = 0; d < 5000 && found < 0; d++) begin
      firstCand(v, cy, cx);
      if (cx == 5'd30) found = d;
      else v = lfsrStep(v);
    end
    if (found < 0) begin
      check("sweep_setup_found", found, 0);
      return;
    end
    repeat (found) @(negedge Clock);
    firstCand(mLfsr, cy, cx);
    py1[0] = cy; px1[0] = cx;
    pushExp(1, 0, 1, de);
    e = q1.pop_back();
    e.fy = (cy == 5'd22) ? 5'd1 : cy + 5'd1;
    e.fx = 5'd1;
    q1.push_back(e);
    Request1 = 1'b1;
    @(negedge Clock);
    Request1 = 1'b0;
    waitEdge(de + 2);
    check("dut1_queue_drained", q1.size(), 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int de, startEdge, startDones, found;
    for (int i = 0; i < 16; i++) begin
      py0[i] = '0; px0[i] = '0; py1[i] = '0; px1[i] = '0;
    end

    // reset with the clock stopped
    #1 ResetN = 1'b0;
    #2;
    check("reset_food_y", int'(FoodY0), 5);
    check("reset_food_x", int'(FoodX0), 10);
    check("reset_busy", int'(Busy0), 0);
    check("reset_done", int'(Done0), 0);
    check("reset_piece_index", int'(PieceIndex0), 0);
    check("reset_dut1_food_x", int'(FoodX1), 10);
    #2 ResetN = 1'b1;
    #1 clkEn = 1'b1;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check("lfsr_after_3_steps", int'(dut0.lfsr), 'h389C);

    // single piece
    py0[0] = 5'd5; px0[0] = 5'd5;
    @(negedge Clock); pulse(0, 0, 8);
    repeat (7) @(negedge Clock);
    pulse(0, 0, 8);

    // collision: piece 2 sits on the first candidate
    begin
      logic [4:0] cy, cx;
      @(negedge Clock);
      firstCand(mLfsr, cy, cx);
      py0[0] = 5'd1;  px0[0] = 5'd1;
      py0[1] = 5'd1;  px0[1] = 5'd2;
      py0[2] = cy;    px0[2] = cx;
      py0[3] = 5'd1;  px0[3] = 5'd3;
      pulse(0, 3, 8);
    end

    // sweep mode on the MAX_TRIES=1 instance
    sweepTest();
    repeat (13) @(negedge Clock);
    sweepTest();

    // Request held high: back-to-back commits with a full body
    for (int i = 0; i < 16; i++) begin py0[i] = 5'd10; px0[i] = 5'(5 + i); end
    @(negedge Clock);
    startEdge = edgeCnt; startDones = doneCnt0;
    pushExp(0, 15, 8, de);
    Request0 = 1'b1;
    for (int n = 0; n < 100; n++) begin
      waitEdge(de);
      if (edgeCnt - startEdge >= 200) break;
      pushExp(0, 15, 8, de);
    end
    Request0 = 1'b0;
    @(negedge Clock); @(negedge Clock);
    check("held_queue_drained", q0.size(), 0);
    check("held_multiple_dones", int'(doneCnt0 - startDones >= 2), 1);

    // abort mid-scan at piece 2
    for (int i = 0; i < 16; i++) begin py0[i] = '0; px0[i] = '0; end
    py0[0] = 5'd2; px0[0] = 5'd1;
    py0[1] = 5'd2; px0[1] = 5'd2;
    py0[2] = 5'd2; px0[2] = 5'd3;
    py0[3] = 5'd2; px0[3] = 5'd4;
    @(negedge Clock);
    pushExp(0, 3, 8, de);
    Request0 = 1'b1;
    @(negedge Clock);
    Request0 = 1'b0;
    found = 0;
    for (int n = 0; n < 200 && found == 0; n++) begin
      if (Busy0 && PieceIndex0 == 4'd2) found = 1;
      else @(negedge Clock);
    end
    check("abort_reached_scan_2", found, 1);
    #1 ResetN = 1'b0;
    #1;
    check("abort_busy", int'(Busy0), 0);
    check("abort_food_x", int'(FoodX0), 10);
    check("abort_food_y", int'(FoodY0), 5);
    check("abort_done", int'(Done0), 0);
    check("abort_piece_index", int'(PieceIndex0), 0);
    q0.delete();
    repeat (2) @(negedge Clock);
    ResetN = 1'b1;
    startDones = doneCnt0;
    repeat (30) @(negedge Clock);
    check("no_done_after_abort", doneCnt0 - startDones, 0);

    // recovery after abort
    py0[0] = 5'd5; px0[0] = 5'd5;
    @(negedge Clock); pulse(0, 0, 8);

    check("final_q0_empty", q0.size(), 0);
    check("final_q1_empty", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
